// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
// Optional hit/miss counters (hit_cnt_o, miss_cnt_o) are built when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int INDEX_W    = 5,
  parameter int LINE_BYTES = 32,
  parameter int TAG_W      = 32 - INDEX_W - 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int NUM_LINES = 2 ** INDEX_W;
  localparam int LINE_W    = LINE_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] idx;
  logic [OFF_W-3:0]   word_sel;
  logic [LINE_W-1:0]  line;
  logic [31:0]        rd_word;
  logic [31:0]        last_data;
  logic               req;
  logic               hit;
  logic               idle_hit;
  logic               idle_miss;
  logic               store_hit;
  logic               refill;
  logic               unused_addr_bits;

  assign req_tag          = p1_addr_i[31 -: TAG_W];
  assign idx              = p1_addr_i[OFF_W +: INDEX_W];
  assign word_sel         = p1_addr_i[OFF_W-1:2];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign line      = data_mem[idx];
  assign rd_word   = line[{word_sel, 5'd0} +: 32];
  assign hit       = valid[idx] & (tag_mem[idx] == req_tag);
  assign idle_hit  = (state == IDLE) & req & hit;
  assign idle_miss = (state == IDLE) & req & ~hit;
  // A simultaneous read+write request is serviced as a store.
  assign store_hit = idle_hit & p1_MemWrite_i;
  assign refill    = (state == ALLOCATE) & mem_ack_i;

  assign p1_data_o  = idle_hit ? rd_word : last_data;
  assign p1_stall_o = (state != IDLE) | (req & ~hit);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (idle_miss) begin
          next_state = (valid[idx] & dirty[idx]) ? WRITEBACK : ALLOCATE;
        end else begin
          next_state = IDLE;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          next_state = ALLOCATE;
        end else begin
          next_state = WRITEBACK;
        end
      end
      ALLOCATE: begin
        if (mem_ack_i) begin
          next_state = IDLE;
        end else begin
          next_state = ALLOCATE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (refill) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (store_hit) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Array writes are suppressed during reset so an abandoned line keeps its contents.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill) begin
        data_mem[idx] <= mem_data_i;
        tag_mem[idx]  <= req_tag;
      end else if (store_hit) begin
        data_mem[idx][{word_sel, 5'd0} +: 32] <= p1_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_data <= 32'h0000_0000;
    end else if (idle_hit) begin
      last_data <= rd_word;
    end
  end

  // Victim tag/line are captured on the miss edge; enable stays high across the phase change.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'h0000_0000;
      mem_data_o   <= 256'h0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_miss) begin
            mem_enable_o <= 1'b1;
            if (valid[idx] & dirty[idx]) begin
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_mem[idx], idx, {OFF_W{1'b0}}};
              mem_data_o  <= line;
            end else begin
              mem_write_o <= 1'b0;
              mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= {req_tag, idx, {OFF_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
          end
        end
        default: begin
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= 32'd0;
      miss_cnt_o <= 32'd0;
    end else begin
      if (idle_hit) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (idle_miss) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: vector table replayed through a scoreboard queue,
// a behavioural line memory with programmable ack latency, and reset-mid-miss / hold sequences.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
`ifdef DCACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          exp_stalls;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_wb;
    logic [31:0] exp_wb_addr;
    int          wb_word;
    logic [31:0] exp_wb_val;
    logic [31:0] exp_rd_addr;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];
  vec_t sb_q [$];
  vec_t e;

  logic [255:0] tb_mem [logic [31:0]];
  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  function automatic logic [31:0] pat(input logic [31:0] a, input int w);
    return a ^ (32'h0101_0101 * 32'(w)) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [255:0] line_at(input logic [31:0] a);
    logic [255:0] l;
    if (tb_mem.exists(a)) return tb_mem[a];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = pat(a, w);
    return l;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one request (called at a negedge), services memory with ack on the lat-th enable
  // cycle of each transaction, and returns once stall drops.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat,
                        output int stalls, output logic [31:0] rdata, output bit done,
                        output bit wb_seen, output logic [31:0] wb_addr,
                        output logic [255:0] wb_line, output logic [31:0] rd_addr,
                        output logic en_at_end);
    int en_cnt;
    en_cnt = 0; stalls = 0; done = 0; wb_seen = 0;
    wb_addr = 32'h0; wb_line = 256'h0; rd_addr = 32'hFFFF_FFFF; rdata = 32'h0; en_at_end = 1'b1;
    p1_MemRead_i = rd; p1_MemWrite_i = wr; p1_addr_i = addr; p1_data_i = wd;
    for (int c = 0; c < 300; c++) begin
      mem_ack_i = 1'b0;
      if (mem_enable_o) begin
        en_cnt++;
        if (en_cnt == lat) begin
          mem_ack_i = 1'b1;
          en_cnt = 0;
          if (mem_write_o) begin
            wb_seen = 1; wb_addr = mem_addr_o; wb_line = mem_data_o;
            tb_mem[mem_addr_o] = mem_data_o;
          end else begin
            rd_addr = mem_addr_o;
            mem_data_i = line_at(mem_addr_o);
          end
        end
      end
      #1;
      if (!p1_stall_o) begin
        rdata = p1_data_o; en_at_end = mem_enable_o; done = 1;
        break;
      end
      stalls++;
      @(negedge clk_i);
    end
    @(negedge clk_i);
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0; mem_ack_i = 1'b0;
  endtask

  initial begin
    int stalls;
    logic [31:0] rdata, wb_addr, rd_addr;
    logic [255:0] wb_line;
    bit done, wb_seen;
    logic en_end;
    logic [255:0] l40;

    l40 = line_at(32'h40);
    l40[31:0] = 32'hDEAD_BEEF;
    tb_mem[32'h40] = l40;

    //           rd    wr    addr         wdata         lat stl chk   exp_data             wb    wb_addr      wbw wb_val         rd_addr
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        10, 11, 1'b1, 32'hDEAD_BEEF,      1'b0, 32'h0,        0, 32'h0,        32'h40};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0044, 32'h1234_5678, 1,  0, 1'b0, 32'h0,              1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1,  0, 1'b1, 32'h1234_5678,      1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1,  0, 1'b1, 32'hDEAD_BEEF,      1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0440, 32'h0,        10, 21, 1'b1, pat(32'h440, 0),    1'b1, 32'h40,       1, 32'h1234_5678, 32'h440};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 3,  4, 1'b0, 32'h0,              1'b0, 32'h0,        0, 32'h0,        32'h80};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         1,  0, 1'b1, 32'hCAFE_F00D,      1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0084, 32'h0,         1,  0, 1'b1, pat(32'h80, 1),     1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_1080, 32'h0,         2,  5, 1'b1, pat(32'h1080, 0),   1'b1, 32'h80,       0, 32'hCAFE_F00D, 32'h1080};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,         1,  2, 1'b1, 32'hDEAD_BEEF,      1'b0, 32'h0,        0, 32'h0,        32'h40};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,         1,  0, 1'b1, 32'h1234_5678,      1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 32'h0000_009C, 32'h0,         4,  5, 1'b1, pat(32'h80, 7),     1'b0, 32'h0,        0, 32'h0,        32'h80};
    vecs[12] = '{1'b1, 1'b0, 32'h0000_0080, 32'h0,         1,  0, 1'b1, 32'hCAFE_F00D,      1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_03E0, 32'h0,         1,  2, 1'b1, pat(32'h3E0, 0),    1'b0, 32'h0,        0, 32'h0,        32'h3E0};
    vecs[14] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h0BAD_F00D, 1,  0, 1'b0, 32'h0,              1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[15] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1,  0, 1'b1, 32'h0BAD_F00D,      1'b0, 32'h0,        0, 32'h0,        32'h0};
    vecs[16] = '{1'b1, 1'b0, 32'h0000_07E0, 32'h0,         2,  5, 1'b1, pat(32'h7E0, 0),    1'b1, 32'h3E0,      7, 32'h0BAD_F00D, 32'h7E0};
    vecs[17] = '{1'b1, 1'b0, 32'h0000_07E4, 32'h0,         1,  0, 1'b1, pat(32'h7E0, 1),    1'b0, 32'h0,        0, 32'h0,        32'h0};

    rst_i = 1'b1; p1_addr_i = 32'h0; p1_data_i = 32'h0;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0; mem_data_i = 256'h0; mem_ack_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_enable", mem_enable_o, 1'b0);
    chk("rst_write", mem_write_o, 1'b0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_mdata", mem_data_o, 256'h0);
    chk("rst_stall", p1_stall_o, 1'b0);
    chk("rst_pdata", p1_data_o, 32'h0);
    @(negedge clk_i);

    for (int i = 0; i < NVEC; i++) begin
      sb_q.push_back(vecs[i]);
      access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].lat,
             stalls, rdata, done, wb_seen, wb_addr, wb_line, rd_addr, en_end);
      e = sb_q.pop_front();
      exp_hits++;
      if (e.exp_stalls > 0) exp_misses++;
      chk($sformatf("v%0d_done", i), done, 1'b1);
      chk($sformatf("v%0d_stalls", i), stalls, e.exp_stalls);
      chk($sformatf("v%0d_en_low", i), en_end, 1'b0);
      chk($sformatf("v%0d_wb_seen", i), wb_seen, e.exp_wb);
      if (e.chk_data) chk($sformatf("v%0d_data", i), rdata, e.exp_data);
      if (e.exp_wb) begin
        chk($sformatf("v%0d_wb_addr", i), wb_addr, e.exp_wb_addr);
        chk($sformatf("v%0d_wb_word", i), wb_line[e.wb_word*32 +: 32], e.exp_wb_val);
      end
      if (e.exp_stalls > 0) chk($sformatf("v%0d_rd_addr", i), rd_addr, e.exp_rd_addr);
    end

    // With no request, load data holds its last value and nothing is issued.
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("hold_data", p1_data_o, vecs[NVEC-1].exp_data);
      chk("hold_stall", p1_stall_o, 1'b0);
      chk("hold_enable", mem_enable_o, 1'b0);
      @(negedge clk_i);
    end

`ifdef DCACHE_STATS_EN
    chk("hit_cnt", hit_cnt_o, 32'(exp_hits));
    chk("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif

    // Reset during ALLOCATE cycle 5, late ack at cycle 7.
    p1_MemRead_i = 1'b1; p1_addr_i = 32'h0000_00C0;
    #1;
    chk("rm_miss_stall", p1_stall_o, 1'b1);
    @(negedge clk_i);
    #1;
    chk("rm_alloc_en", mem_enable_o, 1'b1);
    chk("rm_alloc_addr", mem_addr_o, 32'hC0);
    repeat (4) @(negedge clk_i);
    rst_i = 1'b1; p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rm_en_after_rst", mem_enable_o, 1'b0);
    chk("rm_stall_after_rst", p1_stall_o, 1'b0);
    @(negedge clk_i);
    mem_ack_i = 1'b1;
    mem_data_i = line_at(32'hC0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    #1;
    chk("rm_late_ack_en", mem_enable_o, 1'b0);
    chk("rm_late_ack_stall", p1_stall_o, 1'b0);
    @(negedge clk_i);
    exp_hits = 0; exp_misses = 0;

    access(1'b1, 1'b0, 32'h40, 32'h0, 1, stalls, rdata, done, wb_seen, wb_addr, wb_line, rd_addr, en_end);
    exp_hits++; exp_misses++;
    chk("rm_reload_stalls", stalls, 2);
    chk("rm_reload_data", rdata, 32'hDEAD_BEEF);
    chk("rm_reload_wb", wb_seen, 1'b0);
    access(1'b1, 1'b0, 32'hC4, 32'h0, 1, stalls, rdata, done, wb_seen, wb_addr, wb_line, rd_addr, en_end);
    exp_hits++; exp_misses++;
    chk("rm_c0_stalls", stalls, 2);
    chk("rm_c0_data", rdata, pat(32'hC0, 1));

`ifdef DCACHE_STATS_EN
    chk("hit_cnt_post_rst", hit_cnt_o, 32'(exp_hits));
    chk("miss_cnt_post_rst", miss_cnt_o, 32'(exp_misses));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
